// File: rtl/dmem_rmw_ctrl_if.sv
// Load/store-stage and data-RAM signals of the read-modify-write memory controller.
// The slave modport is the controller's view; master is the pipeline/RAM side.
interface dmem_rmw_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [29:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req, we, size, sign, addr, wdata, mem_rdata,
    output ready, done, err, rdata, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output req, we, size, sign, addr, wdata, mem_rdata,
    input  ready, done, err, rdata, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/dmem_rmw_ctrl.sv
// Data-memory controller for a word-only RAM: sub-word stores are done as read-modify-write,
// sub-word loads are lane-selected and sign/zero-extended.
module dmem_rmw_ctrl (
  input logic           clk,
  input logic           rst_n,
  dmem_rmw_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StRwait,
    StWrite,
    StResp,
    StErr
  } stateT;

  stateT       stateQ, stateD;
  logic        weQ;
  logic [1:0]  sizeQ;
  logic        signQ;
  logic [1:0]  addrLowQ;
  logic [15:0] wdataQ;
  logic [29:0] memAddrQ;
  logic [31:0] memWdataQ;
  logic [31:0] rdataQ;

  logic        accept;
  logic        misaligned;
  logic        wordStore;
  logic [3:0]  laneMask;
  logic [31:0] newData;
  logic [31:0] merged;
  logic [31:0] shifted;
  logic [31:0] loadData;

  assign accept     = (stateQ == StIdle) && bus.req;
  assign misaligned = (bus.size == 2'b01 && bus.addr[0]) ||
                      (bus.size[1] && bus.addr[1:0] != 2'b00);
  assign wordStore  = bus.we && bus.size[1];

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (bus.req) begin
          if (misaligned)     stateD = StErr;
          else if (wordStore) stateD = StWrite;
          else                stateD = StRead;
        end
      end
      StRead:  stateD = StRwait;
      StRwait: stateD = weQ ? StWrite : StResp;
      StWrite: stateD = StResp;
      StResp:  stateD = StIdle;
      StErr:   stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    laneMask = 4'b1111;
    if (sizeQ == 2'b00)      laneMask = 4'b0001 << addrLowQ;
    else if (sizeQ == 2'b01) laneMask = addrLowQ[1] ? 4'b1100 : 4'b0011;
  end

  // Replicate store data across lanes so the mask alone picks what lands where.
  always_comb begin
    newData = {wdataQ, wdataQ};
    if (sizeQ == 2'b00) newData = {4{wdataQ[7:0]}};
    merged = bus.mem_rdata;
    for (int k = 0; k < 4; k++) begin
      if (laneMask[k]) merged[8*k +: 8] = newData[8*k +: 8];
    end
  end

  always_comb begin
    shifted  = bus.mem_rdata >> {addrLowQ, 3'b000};
    loadData = bus.mem_rdata;
    if (sizeQ == 2'b00)      loadData = {{24{signQ & shifted[7]}}, shifted[7:0]};
    else if (sizeQ == 2'b01) loadData = {{16{signQ & shifted[15]}}, shifted[15:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= StIdle;
      weQ       <= 1'b0;
      sizeQ     <= 2'b00;
      signQ     <= 1'b0;
      addrLowQ  <= 2'b00;
      wdataQ    <= 16'h0000;
      memAddrQ  <= 30'h0;
      memWdataQ <= 32'h0;
      rdataQ    <= 32'h0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        weQ      <= bus.we;
        sizeQ    <= bus.size;
        signQ    <= bus.sign;
        addrLowQ <= bus.addr[1:0];
        wdataQ   <= bus.wdata[15:0];
        memAddrQ <= bus.addr[31:2];
        if (wordStore) memWdataQ <= bus.wdata;
      end
      if (stateQ == StRwait) begin
        if (weQ) memWdataQ <= merged;
        else     rdataQ    <= loadData;
      end
    end
  end

  assign bus.ready     = (stateQ == StIdle);
  assign bus.done      = (stateQ == StResp) || (stateQ == StErr);
  assign bus.err       = (stateQ == StErr);
  assign bus.mem_re    = (stateQ == StRead);
  assign bus.mem_we    = (stateQ == StWrite);
  assign bus.mem_addr  = memAddrQ;
  assign bus.mem_wdata = memWdataQ;
  assign bus.rdata     = rdataQ;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Directed bench for dmem_rmw_ctrl with a registered-read word RAM model.
module tb_dmem_rmw_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b1;
  logic [31:0] ram [0:255];

  dmem_rmw_ctrl_if bus ();

  dmem_rmw_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      ram[8'h40] <= 32'h11223344;
      ram[8'h41] <= 32'h55667788;
      ram[8'h80] <= 32'h00000000;
    end else begin
      if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end
  end

  int nChecks = 0;
  int nFails = 0;
  int reOff, weOff, doneOff, reCnt, weCnt, bothCnt;
  logic errAtDone, readyAfter, doneAfter;
  logic [29:0] reAddr, weAddr;
  logic [31:0] weData, rdAtDone;

  task automatic doAccess(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    nChecks++;
    if (bus.ready !== 1'b1) begin nFails++; $display("FAIL ready_before: got %b want 1", bus.ready); end
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign = sg; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    #1 bus.req = 1'b0;
    reOff = -1; weOff = -1; doneOff = -1; reCnt = 0; weCnt = 0; bothCnt = 0;
    errAtDone = 1'b0; rdAtDone = 32'h0; reAddr = 30'h0; weAddr = 30'h0; weData = 32'h0;
    for (int k = 1; k <= 8 && doneOff < 0; k++) begin
      @(negedge clk);
      if (bus.mem_re) begin reCnt++; if (reOff < 0) reOff = k; reAddr = bus.mem_addr; end
      if (bus.mem_we) begin weCnt++; weOff = k; weAddr = bus.mem_addr; weData = bus.mem_wdata; end
      if (bus.mem_re && bus.mem_we) bothCnt++;
      if (bus.done) begin doneOff = k; errAtDone = bus.err; rdAtDone = bus.rdata; end
    end
    nChecks++;
    if (doneOff < 0) begin nFails++; $display("FAIL done_timeout: got none want done within 8"); end
    @(negedge clk);
    readyAfter = bus.ready;
    doneAfter = bus.done;
    nChecks++;
    if (bothCnt !== 0) begin nFails++; $display("FAIL re_we_overlap: got %0d want 0", bothCnt); end
    nChecks++;
    if (readyAfter !== 1'b1 || doneAfter !== 1'b0) begin
      nFails++; $display("FAIL ready_after: got ready=%b done=%b want 1/0", readyAfter, doneAfter);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    nChecks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.rdata !== 32'h0 ||
        bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 30'h0 ||
        bus.mem_wdata !== 32'h0) begin
      nFails++;
      $display("FAIL reset_vals: got rdy=%b dn=%b er=%b rd=%h re=%b we=%b ma=%h wd=%h want 1 0 0 0 0 0 0 0",
               bus.ready, bus.done, bus.err, bus.rdata, bus.mem_re, bus.mem_we, bus.mem_addr,
               bus.mem_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_byte_store;
    doAccess(1'b1, 2'b00, 1'b0, 32'h102, 32'h123456AB);
    nChecks++;
    if (reOff !== 1 || weOff !== 3 || doneOff !== 4) begin
      nFails++; $display("FAIL bst_timing: got re=%0d we=%0d done=%0d want 1 3 4", reOff, weOff, doneOff);
    end
    nChecks++;
    if (weData !== 32'h11AB3344) begin nFails++; $display("FAIL bst_wdata: got %h want 11ab3344", weData); end
    nChecks++;
    if (reAddr !== 30'h40 || weAddr !== 30'h40) begin
      nFails++; $display("FAIL bst_addr: got %h/%h want 40/40", reAddr, weAddr);
    end
    nChecks++;
    if (errAtDone !== 1'b0 || reCnt !== 1 || weCnt !== 1) begin
      nFails++; $display("FAIL bst_misc: got err=%b re=%0d we=%0d want 0 1 1", errAtDone, reCnt, weCnt);
    end
    nChecks++;
    if (ram[8'h40] !== 32'h11AB3344) begin nFails++; $display("FAIL bst_ram: got %h want 11ab3344", ram[8'h40]); end
  endtask

  task automatic test_load_byte;
    doAccess(1'b0, 2'b00, 1'b1, 32'h102, 32'h0);
    nChecks++;
    if (doneOff !== 3 || weCnt !== 0 || reOff !== 1) begin
      nFails++; $display("FAIL lb_timing: got done=%0d we=%0d re=%0d want 3 0 1", doneOff, weCnt, reOff);
    end
    nChecks++;
    if (rdAtDone !== 32'hFFFFFFAB) begin nFails++; $display("FAIL lb_signed: got %h want ffffffab", rdAtDone); end
    doAccess(1'b0, 2'b00, 1'b0, 32'h102, 32'h0);
    nChecks++;
    if (rdAtDone !== 32'h000000AB) begin nFails++; $display("FAIL lb_zero: got %h want 000000ab", rdAtDone); end
    doAccess(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    nChecks++;
    if (rdAtDone !== 32'h00000011) begin nFails++; $display("FAIL lb_lane3: got %h want 00000011", rdAtDone); end
  endtask

  task automatic test_half;
    doAccess(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    nChecks++;
    if (rdAtDone !== 32'h000011AB) begin nFails++; $display("FAIL lh_zero: got %h want 000011ab", rdAtDone); end
    doAccess(1'b1, 2'b01, 1'b0, 32'h100, 32'hFFFF8001);
    nChecks++;
    if (weOff !== 3 || doneOff !== 4 || weData !== 32'h11AB8001) begin
      nFails++; $display("FAIL sh_write: got we=%0d done=%0d data=%h want 3 4 11ab8001", weOff, doneOff, weData);
    end
    nChecks++;
    if (ram[8'h40] !== 32'h11AB8001) begin nFails++; $display("FAIL sh_ram: got %h want 11ab8001", ram[8'h40]); end
    doAccess(1'b0, 2'b01, 1'b1, 32'h100, 32'h0);
    nChecks++;
    if (rdAtDone !== 32'hFFFF8001) begin nFails++; $display("FAIL lh_signed: got %h want ffff8001", rdAtDone); end
  endtask

  task automatic test_word;
    doAccess(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF);
    nChecks++;
    if (reCnt !== 0 || weOff !== 1 || weCnt !== 1 || doneOff !== 2) begin
      nFails++; $display("FAIL sw_timing: got re=%0d we=%0d/%0d done=%0d want 0 1/1 2", reCnt, weOff, weCnt, doneOff);
    end
    nChecks++;
    if (weAddr !== 30'h80 || weData !== 32'hDEADBEEF) begin
      nFails++; $display("FAIL sw_bus: got addr=%h data=%h want 80 deadbeef", weAddr, weData);
    end
    doAccess(1'b0, 2'b11, 1'b1, 32'h200, 32'h0);
    nChecks++;
    if (doneOff !== 3 || rdAtDone !== 32'hDEADBEEF) begin
      nFails++; $display("FAIL lw: got done=%0d data=%h want 3 deadbeef", doneOff, rdAtDone);
    end
  endtask

  task automatic test_misaligned;
    doAccess(1'b1, 2'b01, 1'b0, 32'h101, 32'h00001234);
    nChecks++;
    if (doneOff !== 1 || errAtDone !== 1'b1 || reCnt !== 0 || weCnt !== 0) begin
      nFails++; $display("FAIL mis_sh: got done=%0d err=%b re=%0d we=%0d want 1 1 0 0", doneOff, errAtDone, reCnt, weCnt);
    end
    nChecks++;
    if (rdAtDone !== 32'hDEADBEEF || ram[8'h40] !== 32'h11AB8001) begin
      nFails++; $display("FAIL mis_sh_keep: got rd=%h ram=%h want deadbeef 11ab8001", rdAtDone, ram[8'h40]);
    end
    doAccess(1'b0, 2'b10, 1'b0, 32'h202, 32'h0);
    nChecks++;
    if (doneOff !== 1 || errAtDone !== 1'b1 || reCnt !== 0 || weCnt !== 0) begin
      nFails++; $display("FAIL mis_lw: got done=%0d err=%b re=%0d we=%0d want 1 1 0 0", doneOff, errAtDone, reCnt, weCnt);
    end
    nChecks++;
    if (rdAtDone !== 32'hDEADBEEF || ram[8'h80] !== 32'hDEADBEEF) begin
      nFails++; $display("FAIL mis_lw_keep: got rd=%h ram=%h want deadbeef deadbeef", rdAtDone, ram[8'h80]);
    end
  endtask

  task automatic test_reset_abort;
    logic sawWe;
    sawWe = 1'b0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.sign = 1'b0;
    bus.addr = 32'h104; bus.wdata = 32'h000000CC;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    nChecks++;
    if (bus.mem_re !== 1'b1) begin nFails++; $display("FAIL abort_read: got %b want 1", bus.mem_re); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.rdata !== 32'h0 ||
        bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 30'h0 ||
        bus.mem_wdata !== 32'h0) begin
      nFails++;
      $display("FAIL abort_vals: got rdy=%b dn=%b er=%b rd=%h re=%b we=%b ma=%h wd=%h want 1 0 0 0 0 0 0 0",
               bus.ready, bus.done, bus.err, bus.rdata, bus.mem_re, bus.mem_we, bus.mem_addr,
               bus.mem_wdata);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.mem_we) sawWe = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.mem_we) sawWe = 1'b1;
    end
    nChecks++;
    if (sawWe !== 1'b0 || ram[8'h41] !== 32'h55667788) begin
      nFails++; $display("FAIL abort_ram: got we=%b ram=%h want 0 55667788", sawWe, ram[8'h41]);
    end
    doAccess(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
    nChecks++;
    if (rdAtDone !== 32'h55667788 || errAtDone !== 1'b0) begin
      nFails++; $display("FAIL abort_load: got %h err=%b want 55667788 0", rdAtDone, errAtDone);
    end
  endtask

  task automatic test_back_to_back;
    int doneCnt, lastDone, wes;
    doneCnt = 0; lastDone = -1; wes = 0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.sign = 1'b0;
    bus.addr = 32'h200; bus.wdata = 32'h01020304;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus.done) begin doneCnt++; lastDone = k; end
      if (bus.mem_we) wes++;
    end
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    nChecks++;
    if (doneCnt !== 2 || lastDone !== 5 || wes !== 2) begin
      nFails++; $display("FAIL b2b: got done=%0d last=%0d we=%0d want 2 5 2", doneCnt, lastDone, wes);
    end
    nChecks++;
    if (ram[8'h80] !== 32'h01020304 || bus.ready !== 1'b1) begin
      nFails++; $display("FAIL b2b_end: got ram=%h rdy=%b want 01020304 1", ram[8'h80], bus.ready);
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    test_reset;
    test_byte_store;
    test_load_byte;
    test_half;
    test_word;
    test_misaligned;
    test_reset_abort;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
